cache_snoop_responder: RTL
==========================

// Module: cache_snoop_responder
// PURPOSE
//  Snoop-side responder for one L1 cache. It services BusRd/BusRdX/BusUpgr ops on the shared Address_Com bus.
//  Holds per-set tag+MESI directory, filled by processor-side controller; computes MESI transitions, Shared/HitM, flush handshake.
//  Sits beside the processor-side LRU/MESI controller.
// PARAMETERS
//  ADDRESSSIZE    `ADDRESSSIZE (32)  address width
//  INDEX_SIZE     `INDEX_SIZE        set index bits; NUM_OF_SETS = 2**INDEX_SIZE
//  TAG_SIZE       `TAG_SIZE          tag bits
//  ASSOCIATIVITY  4                  ways; way id is 2 bits
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  Com_Bus_Req   in   1   snoop request valid; sampled only in IDLE
//  Com_Bus_Op    in   2   00 none, 01 BusRd, 10 BusRdX, 11 BusUpgr
//  Com_Bus_Self  in   1   request issued by own cache: complete with no state change, no response
//  Address_Com   in   ADDRESSSIZE  snoop address
//  Snoop_busy    out  1   high whenever FSM not IDLE
//  Shared        out  1   asserted in RESPOND on BusRd hit (any valid state)
//  HitM          out  1   asserted RESPOND..FLUSH when hit line is M and op is BusRd/BusRdX
//  Flush_req     out  1   request owner to drive line onto Data_Bus_Com
//  Flush_way     out  2   way to flush; Flush_index = latched index
//  Flush_index   out  INDEX_SIZE
//  Flush_ack     in   1   flush data transferred
//  Snoop_done    out  1   1-cycle pulse, snoop complete
//  Proto_err     out  1   1-cycle pulse in RESPOND: BusUpgr hit on E or M
//  Fill_en       in   1   write directory entry
//  Fill_index/Fill_way/Fill_tag/Fill_state  in  INDEX_SIZE/2/TAG_SIZE/2  entry written
//  Fill_ready    out  1   low when Snoop_busy and Fill_index == latched index
// BEHAVIOUR
//  Reset: FSM=IDLE, every directory state=I, all outputs 0.
//  IDLE: Com_Bus_Req & op!=00 -> latch op/index/tag/self -> LOOKUP. Ops while busy are ignored.
//  LOOKUP (1 cyc): compare latched tag vs 4 ways with state!=I.
//    At most one way hits; multiple hits are an error and the lowest way is used. -> RESPOND.
//  RESPOND (1 cyc): Shared/HitM/Proto_err driven.
//    HitM -> FLUSH; else apply next state -> DONE.
//  FLUSH: Flush_req held until Flush_ack (same cycle counts); then apply next state -> DONE.
//  DONE: Snoop_done=1 -> IDLE.
//  Latency: accept at cycle 0, Snoop_done at cycle 3 if no flush.
//    With flush, Snoop_done comes 1 cycle after the ack cycle.
//  Next state: BusRd M->S (after flush), E->S, S->S. BusRdX any->I (M after flush). BusUpgr S->I, E/M->I plus Proto_err.
//  Miss or Self: no outputs except Snoop_done; directory unchanged.
//  Fill: Fill_en & Fill_ready writes entry next edge.
//    Fill_en while !Fill_ready is dropped (bench asserts never occurs).
//  rst mid-operation: abort immediately; Flush_req drops; no Snoop_done.
// CONFIGURATION
//  SNOOP_INV_TO_LRU_EN defined: extra outputs Inv_valid (1), Inv_index, Inv_way.
//    Pulse the same cycle a snoop sets a valid line to I, so LRU steers replacement to that way.
//  Undefined: ports absent; no hint logic.
// STRUCTURE
//  cache_def_I_0.v: MESI encodings (I=00,S=01,E=10,M=11), bus op codes, size macros.
//  Sub-module snoop_tag_match: 4-way tag/valid compare -> one-hot hit + encoded way + hit state.
// TESTING
//  Fill set 5 way 2 tag 0x3A state E; BusRd same addr -> Shared=1, HitM=0, state S, Snoop_done at cycle 3.
//  Fill way 1 state M; BusRdX -> HitM, Flush_req way 1; ack after 4 cyc -> state I, done next cycle.
//  BusUpgr on E line -> Proto_err pulse, state I; on S line -> I, no error.
//  BusRd to untagged addr -> Shared=0, HitM=0, directory unchanged; Com_Bus_Self=1 on hit -> no change.
//  Fill to latched index while busy -> Fill_ready=0; rst during FLUSH -> IDLE, all states I, no Snoop_done.
//  With SNOOP_INV_TO_LRU_EN: BusRdX hit way 3 set 7 -> Inv_valid pulse, Inv_index=7, Inv_way=3.

Source files
------------

// File: rtl/cache_snoop_responder_pkg.sv
// cache_snoop_responder_pkg: shared sizes, MESI and bus-op encodings, and the
// snoop-side MESI transition used by the responder.
package cache_snoop_responder_pkg;

    localparam int ADDRESSSIZE   = 32;
    localparam int INDEX_SIZE    = 4;
    localparam int OFFSET_SIZE   = 4;
    localparam int TAG_SIZE      = ADDRESSSIZE - INDEX_SIZE - OFFSET_SIZE;
    localparam int NUM_OF_SETS   = 2 ** INDEX_SIZE;
    localparam int ASSOCIATIVITY = 4;
    localparam int WAY_BITS      = 2;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_op_t;

    typedef struct packed {
        logic [1:0]            op;
        logic                  self;
        logic [INDEX_SIZE-1:0] index;
        logic [TAG_SIZE-1:0]   tag;
    } snoop_req_t;

    // A remote read demotes any valid copy to S; every other snoop op kills the line.
    function automatic logic [1:0] next_mesi(input logic [1:0] op, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = MESI_I;
        if (op == BUS_RD && cur != MESI_I) begin
            nxt = MESI_S;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cache_snoop_responder_if.sv
// cache_snoop_responder_if: snoop request bus, snoop response, flush handshake
// and directory fill port. Macro SNOOP_INV_TO_LRU_EN adds the Inv_* hint lines.
interface cache_snoop_responder_if;
    import cache_snoop_responder_pkg::*;

    logic                   Com_Bus_Req;
    logic [1:0]             Com_Bus_Op;
    logic                   Com_Bus_Self;
    logic [ADDRESSSIZE-1:0] Address_Com;

    logic                   Snoop_busy;
    logic                   Shared;
    logic                   HitM;
    logic                   Flush_req;
    logic [WAY_BITS-1:0]    Flush_way;
    logic [INDEX_SIZE-1:0]  Flush_index;
    logic                   Flush_ack;
    logic                   Snoop_done;
    logic                   Proto_err;

    logic                   Fill_en;
    logic [INDEX_SIZE-1:0]  Fill_index;
    logic [WAY_BITS-1:0]    Fill_way;
    logic [TAG_SIZE-1:0]    Fill_tag;
    logic [1:0]             Fill_state;
    logic                   Fill_ready;

`ifdef SNOOP_INV_TO_LRU_EN
    logic                   Inv_valid;
    logic [INDEX_SIZE-1:0]  Inv_index;
    logic [WAY_BITS-1:0]    Inv_way;
`endif

    modport master (
        output Com_Bus_Req, Com_Bus_Op, Com_Bus_Self, Address_Com, Flush_ack,
               Fill_en, Fill_index, Fill_way, Fill_tag, Fill_state,
        input  Snoop_busy, Shared, HitM, Flush_req, Flush_way, Flush_index,
               Snoop_done, Proto_err, Fill_ready
`ifdef SNOOP_INV_TO_LRU_EN
        , input Inv_valid, Inv_index, Inv_way
`endif
    );

    modport slave (
        input  Com_Bus_Req, Com_Bus_Op, Com_Bus_Self, Address_Com, Flush_ack,
               Fill_en, Fill_index, Fill_way, Fill_tag, Fill_state,
        output Snoop_busy, Shared, HitM, Flush_req, Flush_way, Flush_index,
               Snoop_done, Proto_err, Fill_ready
`ifdef SNOOP_INV_TO_LRU_EN
        , output Inv_valid, Inv_index, Inv_way
`endif
    );

endinterface

// File: rtl/cache_snoop_responder_tag_match.sv
// snoop_tag_match: compares one tag against the four ways of a set. Only ways
// in a valid MESI state can hit; if several hit, the lowest way is reported.
module snoop_tag_match
    import cache_snoop_responder_pkg::*;
(
    input  logic [TAG_SIZE-1:0]                     tag,
    input  logic [ASSOCIATIVITY-1:0][TAG_SIZE-1:0]  way_tags,
    input  logic [ASSOCIATIVITY-1:0][1:0]           way_states,
    output logic [ASSOCIATIVITY-1:0]                hit_onehot,
    output logic [WAY_BITS-1:0]                     hit_way,
    output logic [1:0]                              hit_state
);

    logic [ASSOCIATIVITY-1:0] raw_hit;

    // Per-way valid-and-tag-equal compare.
    always_comb begin
        raw_hit = '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            raw_hit[w] = (way_states[w] != MESI_I) && (way_tags[w] == tag);
        end
    end

    // Lowest hitting way wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        hit_onehot = '0;
        hit_way    = '0;
        hit_state  = MESI_I;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (raw_hit[w]) begin
                hit_onehot    = '0;
                hit_onehot[w] = 1'b1;
                hit_way       = WAY_BITS'(w);
                hit_state     = way_states[w];
            end
        end
    end

endmodule

// File: rtl/cache_snoop_responder.sv
// cache_snoop_responder: snoop-side responder for one L1 cache. Keeps a
// tag+MESI directory filled by the processor-side controller, answers snoops
// with Shared/HitM/Proto_err and runs the flush handshake for M lines.
// Macro SNOOP_INV_TO_LRU_EN adds the Inv_* hint pulsed when a snoop kills a line.
//
// state   | meaning
// IDLE    | waiting for a snoop request
// LOOKUP  | tag compare on the latched set, result registered
// RESPOND | Shared/HitM/Proto_err driven; directory update unless flushing
// FLUSH   | Flush_req held until Flush_ack, then directory update
// DONE    | Snoop_done pulse
module cache_snoop_responder
    import cache_snoop_responder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    cache_snoop_responder_if.slave bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_RESPOND = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_q;
    snoop_req_t          req_q;
    logic                hit_q;
    logic [WAY_BITS-1:0] way_q;
    logic [1:0]          hit_state_q;

    logic [TAG_SIZE-1:0] dir_tag   [NUM_OF_SETS][ASSOCIATIVITY];
    logic [1:0]          dir_state [NUM_OF_SETS][ASSOCIATIVITY];

    logic [ASSOCIATIVITY-1:0][TAG_SIZE-1:0] set_tags;
    logic [ASSOCIATIVITY-1:0][1:0]          set_states;
    logic [ASSOCIATIVITY-1:0]               match_onehot;
    logic [WAY_BITS-1:0]                    match_way;
    logic [1:0]                             match_state;

    logic                   accept;
    logic                   busy;
    logic                   responds;
    logic                   flush_needed;
    logic                   apply_update;
    logic [1:0]             next_line;
    logic                   fill_ready;
    logic                   fill_write;
    logic [OFFSET_SIZE-1:0] addr_offset_unused;

    assign addr_offset_unused = bus.Address_Com[OFFSET_SIZE-1:0];

    assign accept = (state_q == ST_IDLE) && bus.Com_Bus_Req && (bus.Com_Bus_Op != BUS_NONE);
    assign busy   = (state_q != ST_IDLE);

    // Own-cache requests and misses walk the FSM but never respond or update.
    assign responds     = hit_q && !req_q.self;
    assign flush_needed = responds && (hit_state_q == MESI_M) &&
                          ((req_q.op == BUS_RD) || (req_q.op == BUS_RDX));
    assign next_line    = next_mesi(req_q.op, hit_state_q);
    assign apply_update = responds &&
                          (((state_q == ST_RESPOND) && !flush_needed) ||
                           ((state_q == ST_FLUSH) && bus.Flush_ack));

    // Blocking fills to the set under snoop keeps the looked-up way stable.
    assign fill_ready = !(busy && (bus.Fill_index == req_q.index));
    assign fill_write = bus.Fill_en && fill_ready;

    // Present the latched set to the tag comparator.
    always_comb begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
            set_tags[w]   = dir_tag[req_q.index][w];
            set_states[w] = dir_state[req_q.index][w];
        end
    end

    snoop_tag_match u_tag_match (
        .tag        (req_q.tag),
        .way_tags   (set_tags),
        .way_states (set_states),
        .hit_onehot (match_onehot),
        .hit_way    (match_way),
        .hit_state  (match_state)
    );

    // Snoop sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (accept) state_q <= ST_LOOKUP;
                ST_LOOKUP:  state_q <= ST_RESPOND;
                ST_RESPOND: state_q <= flush_needed ? ST_FLUSH : ST_DONE;
                ST_FLUSH:   if (bus.Flush_ack) state_q <= ST_DONE;
                ST_DONE:    state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Capture the request on accept and the lookup result one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            hit_state_q <= MESI_I;
        end else begin
            if (accept) begin
                req_q <= '{op:    bus.Com_Bus_Op,
                           self:  bus.Com_Bus_Self,
                           index: bus.Address_Com[OFFSET_SIZE +: INDEX_SIZE],
                           tag:   bus.Address_Com[ADDRESSSIZE-1 -: TAG_SIZE]};
            end
            if (state_q == ST_LOOKUP) begin
                hit_q       <= |match_onehot;
                way_q       <= match_way;
                hit_state_q <= match_state;
            end
        end
    end

    // Directory states: cleared on reset, written by fills and snoop transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_OF_SETS; s++) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    dir_state[s][w] <= MESI_I;
                end
            end
        end else begin
            if (fill_write) begin
                dir_state[bus.Fill_index][bus.Fill_way] <= bus.Fill_state;
            end
            if (apply_update) begin
                dir_state[req_q.index][way_q] <= next_line;
            end
        end
    end

    // Directory tags only matter while the state is valid, so no reset.
    always_ff @(posedge clk) begin
        if (fill_write) begin
            dir_tag[bus.Fill_index][bus.Fill_way] <= bus.Fill_tag;
        end
    end

    assign bus.Snoop_busy  = busy;
    assign bus.Shared      = (state_q == ST_RESPOND) && responds && (req_q.op == BUS_RD);
    assign bus.HitM        = ((state_q == ST_RESPOND) || (state_q == ST_FLUSH)) && flush_needed;
    assign bus.Proto_err   = (state_q == ST_RESPOND) && responds && (req_q.op == BUS_UPGR) &&
                             ((hit_state_q == MESI_E) || (hit_state_q == MESI_M));
    assign bus.Flush_req   = (state_q == ST_FLUSH);
    assign bus.Flush_way   = (state_q == ST_FLUSH) ? way_q : '0;
    assign bus.Flush_index = (state_q == ST_FLUSH) ? req_q.index : '0;
    assign bus.Snoop_done  = (state_q == ST_DONE);
    assign bus.Fill_ready  = fill_ready;

`ifdef SNOOP_INV_TO_LRU_EN
    logic inv_valid;

    // Hint fires on the same cycle the directory entry goes to I.
    assign inv_valid     = apply_update && (next_line == MESI_I);
    assign bus.Inv_valid = inv_valid;
    assign bus.Inv_index = inv_valid ? req_q.index : '0;
    assign bus.Inv_way   = inv_valid ? way_q : '0;
`endif

endmodule
